// File: rtl/serial_frame_rx_bank.sv
// serial_frame_rx_bank: deserialises {addr,data} frames from sen/sd and writes them into a WENn register bank.
// Optional feature macro PARITY_EN: a trailing even-parity bit per frame plus the err_cnt status port.
module serial_frame_rx_bank #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 18,
    parameter int FRAMES = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB_RW,
    output logic [ADDR_W-1:0] RB_A,
    output logic [DATA_W-1:0] RB_D,
    output logic              done,
    output logic [CNT_W-1:0]  abort_cnt,
`ifdef PARITY_EN
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic              overrun
);
`ifdef PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = ADDR_W + DATA_W + PAR_W;
    localparam int CW = $clog2(FRAME_W + 1);
    localparam int GW = $clog2(FRAMES + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-2:0] sr_q, sr_d;
    logic [FRAME_W-1:0] frame;
    logic               rb_rw_q, rb_rw_d;
    logic [ADDR_W-1:0]  rb_a_q, rb_a_d;
    logic [DATA_W-1:0]  rb_d_q, rb_d_d;
    logic [GW-1:0]      good_q, good_d;
    logic [CNT_W-1:0]   abort_q, abort_d;
    logic               over_q, over_d;
    logic               shifting, last, par_ok;
`ifdef PARITY_EN
    logic [CNT_W-1:0]   err_q, err_d;
    assign par_ok  = ~^frame;
    assign err_cnt = err_q;
`else
    assign par_ok = 1'b1;
`endif

    // The incoming bit completes the frame combinationally so the write can launch on the last sampling edge.
    assign frame     = {sr_q, sd};
    assign RB_RW     = rb_rw_q;
    assign RB_A      = rb_a_q;
    assign RB_D      = rb_d_q;
    assign done      = good_q == GW'(FRAMES);
    assign abort_cnt = abort_q;
    assign overrun   = over_q;

    // Next state: bit capture, frame sequencing, write strobe and saturating status counters.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        rb_a_d   = rb_a_q;
        rb_d_d   = rb_d_q;
        good_d   = good_q;
        abort_d  = abort_q;
        over_d   = over_q;
        shifting = !sen && (state_q == IDLE || state_q == SHIFT);
        last     = 1'b0;
`ifdef PARITY_EN
        err_d = err_q;
        if (state_q == WRITE && rb_rw_q)
            err_d = err_q + CNT_W'(err_q != '1);
`endif
        if (shifting) begin
            sr_d    = frame[FRAME_W-2:0];
            cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
            last    = cnt_d == CW'(FRAME_W);
            state_d = last ? WRITE : SHIFT;
        end
        if (sen && state_q == SHIFT) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = abort_q + CNT_W'(abort_q != '1);
        end
        // A gap sampled during the write cycle returns straight to IDLE so one-cycle gaps suffice.
        if (state_q == WRITE || state_q == DRAIN) begin
            state_d = sen ? IDLE : DRAIN;
            over_d  = over_q | !sen;
        end
        if (state_q == WRITE && !rb_rw_q && good_q != GW'(FRAMES))
            good_d = good_q + GW'(1);
        rb_rw_d = !(last && par_ok);
        if (!rb_rw_d) begin
            rb_a_d = frame[FRAME_W-1 -: ADDR_W];
            rb_d_d = frame[FRAME_W-ADDR_W-1 -: DATA_W];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            rb_rw_q <= 1'b1;
            rb_a_q  <= '0;
            rb_d_q  <= '0;
            good_q  <= '0;
            abort_q <= '0;
            over_q  <= 1'b0;
`ifdef PARITY_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            rb_rw_q <= rb_rw_d;
            rb_a_q  <= rb_a_d;
            rb_d_q  <= rb_d_d;
            good_q  <= good_d;
            abort_q <= abort_d;
            over_q  <= over_d;
`ifdef PARITY_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_frame_rx_bank.sv
// tb_serial_frame_rx_bank: randomized frames against a transaction-level model of expected bank writes and status.
module tb_serial_frame_rx_bank;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 18;
    localparam int FRAMES = 8;
    localparam int CNT_W  = 4;
    localparam int SAT    = 2**CNT_W - 1;
`ifdef PARITY_EN
    localparam int FW = ADDR_W + DATA_W + 1;
`else
    localparam int FW = ADDR_W + DATA_W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sen = 1'b1;
    logic sd  = 1'b0;
    logic RB_RW, done, overrun;
    logic [ADDR_W-1:0] RB_A;
    logic [DATA_W-1:0] RB_D;
    logic [CNT_W-1:0]  abort_cnt;
`ifdef PARITY_EN
    logic [CNT_W-1:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int m_abort = 0;
    int m_good = 0;
    int m_err = 0;
    logic m_over = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_w[$];
    int exp_c[$];
    logic [ADDR_W+DATA_W-1:0] mon_w;

    serial_frame_rx_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAMES(FRAMES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sen(sen), .sd(sd),
        .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .done(done), .abort_cnt(abort_cnt),
`ifdef PARITY_EN
        .err_cnt(err_cnt),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every observed write must match the oldest expected one, including the exact cycle.
    always @(negedge clk) begin
        if (rst && !RB_RW) begin
            check("write_expected", 64'(exp_w.size() > 0), 64'(1));
            if (exp_w.size() > 0) begin
                mon_w = exp_w[0];
                check("wr_cycle", 64'(cyc), 64'(exp_c[0]));
                check("wr_addr", 64'(RB_A), 64'(mon_w[ADDR_W+DATA_W-1 -: ADDR_W]));
                check("wr_data", 64'(RB_D), 64'(mon_w[DATA_W-1:0]));
                check("done_before_wr", 64'(done), 64'(m_good >= FRAMES));
                void'(exp_w.pop_front());
                void'(exp_c.pop_front());
                m_good++;
            end
        end
    end

    task automatic tick(input logic s, input logic d);
        @(negedge clk);
        sen = s;
        sd = d;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit bad, input int extra, input int gap);
        logic [FW-1:0] f;
`ifdef PARITY_EN
        f = {a, d, (^{a, d}) ^ bad};
`else
        f = {a, d};
`endif
        for (int i = FW - 1; i >= 0; i--) tick(1'b0, f[i]);
        if (!bad) begin
            exp_w.push_back({a, d});
            exp_c.push_back(cyc + 1);
        end else if (m_err < SAT) begin
            m_err++;
        end
        for (int i = 0; i < extra; i++) tick(1'b0, 1'($urandom));
        if (extra > 0) m_over = 1'b1;
        for (int i = 0; i < gap; i++) tick(1'b1, 1'($urandom));
    endtask

    task automatic abort_frame(input int n, input int gap);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom));
        for (int i = 0; i < gap; i++) tick(1'b1, 1'b0);
        if (m_abort < SAT) m_abort++;
    endtask

    task automatic clear_model();
        exp_w.delete();
        exp_c.delete();
        m_abort = 0;
        m_good = 0;
        m_err = 0;
        m_over = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sen = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic check_state(input string tag);
        repeat (2) tick(1'b1, 1'b0);
        check({tag, ":pending_writes"}, 64'(exp_w.size()), 64'(0));
        check({tag, ":abort_cnt"}, 64'(abort_cnt), 64'(m_abort));
        check({tag, ":overrun"}, 64'(overrun), 64'(m_over));
        check({tag, ":done"}, 64'(done), 64'(m_good >= FRAMES));
`ifdef PARITY_EN
        check({tag, ":err_cnt"}, 64'(err_cnt), 64'(m_err));
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst:RB_RW", 64'(RB_RW), 64'(1));
        check("rst:RB_A", 64'(RB_A), 64'(0));
        check("rst:RB_D", 64'(RB_D), 64'(0));
        check("rst:done", 64'(done), 64'(0));
        check("rst:abort_cnt", 64'(abort_cnt), 64'(0));
        check("rst:overrun", 64'(overrun), 64'(0));
        rst = 1'b1;
        tick(1'b1, 1'b0);
        send(3'b010, 18'h2A5C3, 1'b0, 0, 1);
        check_state("single");
        do_reset();
        for (int a = 0; a < FRAMES; a++) begin
            send(ADDR_W'(a), DATA_W'($urandom), 1'b0, 0, 1);
            if (a == FRAMES - 2) check("done_early", 64'(done), 64'(0));
        end
        check_state("eight");
        send(ADDR_W'(3), DATA_W'($urandom), 1'b0, 0, 1);
        send(ADDR_W'(3), DATA_W'($urandom), 1'b0, 0, 1);
        check_state("dup_after_done");
        abort_frame(10, 1);
        send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 0, 1);
        check_state("abort");
        send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 3, 1);
        check_state("overrun");
        do_reset();
        repeat (60) begin
            case ($urandom % 8)
                0: abort_frame(1 + int'($urandom % (FW - 1)), 1 + int'($urandom % 2));
                1: send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1 + int'($urandom % 3), 1 + int'($urandom % 3));
                default: send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 0, 1 + int'($urandom % 3));
            endcase
        end
        check_state("random");
        repeat (SAT + 2) abort_frame(1 + int'($urandom % (FW - 1)), 1);
        check_state("abort_sat");
`ifdef PARITY_EN
        begin
            int g;
            g = m_good;
            do_reset();
            send(ADDR_W'($urandom), DATA_W'($urandom), 1'b1, 0, 1);
            check_state("bad_parity");
            check("bad_parity:no_count", 64'(m_good), 64'(0));
            send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 0, 1);
            check_state("after_parity");
            g = g + 0;
        end
`endif
        send(ADDR_W'(5), DATA_W'($urandom), 1'b0, 0, 1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'($urandom));
        #2 rst = 1'b0;
        #1;
        check("midrst:RB_RW", 64'(RB_RW), 64'(1));
        check("midrst:RB_A", 64'(RB_A), 64'(0));
        check("midrst:RB_D", 64'(RB_D), 64'(0));
        check("midrst:done", 64'(done), 64'(0));
        check("midrst:abort_cnt", 64'(abort_cnt), 64'(0));
        check("midrst:overrun", 64'(overrun), 64'(0));
        sen = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        tick(1'b1, 1'b0);
        send(ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 0, 1);
        check_state("after_midrst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
